ahb_bram_ctrl: RTL and testbench

//  AHB-Lite slave that drives the dual-port byte-write Block_RAM (write port A, registered read port B).

---
 rtl/ahb_bram_ctrl.sv | 153 +++++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave front end for a dual-port byte-write block RAM (write port A, registered read port B).
// Zero-wait legal transfers, two-cycle ERROR response, same-word write->read forwarding.
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [3:0]            ram_wea,
  output logic [31:0]           ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [3:0]              wr_be_q, wr_be_d;
  logic [3:0]              fwd_be_q, fwd_be_d;
  logic [31:0]             fwd_data_q, fwd_data_d;

  logic                    acc;
  logic                    take;
  logic                    ready_int;
  logic                    illegal;
  logic [3:0]              be_addr;
  logic [ADDR_WIDTH-1:0]   addr_word;
  logic                    unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign addr_word = HADDR[ADDR_WIDTH+1:2];
  assign acc       = HSEL & HREADY & HTRANS[1];
  assign ready_int = (state_q != S_ERR1);
  // Address phases are only taken while this slave is itself ready.
  assign take      = acc & ready_int;

  always_comb begin
    be_addr = 4'b0000;
    illegal = 1'b0;
    case (HSIZE)
      3'd0: be_addr = 4'b0001 << HADDR[1:0];
      3'd1: begin
        be_addr = 4'b0011 << {HADDR[1], 1'b0};
        illegal = HADDR[0];
      end
      3'd2: begin
        be_addr = 4'b1111;
        illegal = |HADDR[1:0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!ready_int) begin
      state_d = S_ERR2;
    end else if (take) begin
      if (illegal) begin
        state_d = S_ERR1;
      end else if (HWRITE) begin
        state_d = S_WR;
      end else begin
        state_d = S_RD;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // Output logic
  always_comb begin
    HREADYOUT = ready_int;
    HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    ram_wea   = 4'b0000;
    HRDATA    = 32'h0;
    if (state_q == S_WR) begin
      ram_wea = wr_be_q;
    end
    if (state_q == S_RD) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8] : ram_doutb[8*i +: 8];
      end
    end
  end

  assign ram_addra = wr_addr_q;
  assign ram_dina  = HWDATA;
  assign ram_addrb = addr_word;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    wr_be_d    = wr_be_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;
    if (take && HWRITE && !illegal) begin
      wr_addr_d = addr_word;
      wr_be_d   = be_addr;
    end
    // The RAM reads old data while the write lands on the same edge, so patch those lanes.
    if (take && !HWRITE) begin
      if ((state_q == S_WR) && (addr_word == wr_addr_q)) begin
        fwd_be_d   = wr_be_q;
        fwd_data_d = HWDATA;
      end else begin
        fwd_be_d   = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      wr_be_q    <= 4'b0000;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      wr_be_q    <= wr_be_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: RAM model, word-array reference model, directed then random bus cycles.
module tb_ahb_bram_ctrl;
  localparam int AW = 11;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam int P_IDLE = 0;
  localparam int P_WR   = 1;
  localparam int P_RD   = 2;
  localparam int P_ERR1 = 3;
  localparam int P_ERR2 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_dina;
  logic [31:0]   ram_doutb;
  logic          rdy_ext;

  assign HREADY = rdy_ext & HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // Block RAM: byte-write port A, read-first registered port B.
  logic [31:0] bram [0:(1<<AW)-1] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_wea[i]) bram[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
    end
    ram_doutb <= bram[ram_addrb];
  end

  // Reference: plain word array updated when a write data phase completes.
  logic [31:0] ref_mem [0:(1<<AW)-1] = '{default: 32'h0};
  int          m_phase;
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  int          total = 0;
  int          bad = 0;
  logic [31:0] obs_hrdata;
  logic [3:0]  obs_wea;
  logic        obs_rdy, obs_resp;

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
    int n, off;
    logic [3:0] m;
    n = 1 << sz;
    off = int'(a[1:0]);
    m = 4'b0000;
    for (int k = 0; k < 4; k++) m[k] = (k >= off) && (k < off + n);
    return m;
  endfunction

  function automatic logic legal(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b0;
    return (int'(a[1:0]) % (1 << sz)) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle, entered at posedge+1: drive address phase and current data-phase HWDATA.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] ad, input logic [31:0] wd, input logic rdy, input logic rst_mid);
    logic [3:0]  e_wea;
    logic [31:0] e_rd;
    logic        e_rdy, e_resp, accepted;
    int          idx;
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = ad; HWDATA = wd; rdy_ext = rdy;
    idx = int'(m_addr[AW+1:2]);
    e_rdy  = (m_phase != P_ERR1);
    e_resp = (m_phase == P_ERR1) || (m_phase == P_ERR2);
    e_wea  = (m_phase == P_WR) ? lanes(m_addr, m_size) : 4'b0000;
    e_rd   = (m_phase == P_RD) ? ref_mem[idx] : 32'h0;
    if (rst_mid) begin
      #1 rst = 1'b1;
      #1;
      chk("rst_wea", {28'h0, ram_wea}, 32'h0);
      chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("rst_hresp", {31'h0, HRESP}, 32'h0);
      chk("rst_hrdata", HRDATA, 32'h0);
      @(posedge clk);
      m_phase = P_IDLE;
      #1 rst = 1'b0;
      return;
    end
    @(negedge clk);
    obs_hrdata = HRDATA; obs_wea = ram_wea; obs_rdy = HREADYOUT; obs_resp = HRESP;
    chk("hreadyout", {31'h0, HREADYOUT}, {31'h0, e_rdy});
    chk("hresp", {31'h0, HRESP}, {31'h0, e_resp});
    chk("wea", {28'h0, ram_wea}, {28'h0, e_wea});
    chk("hrdata", HRDATA, e_rd);
    chk("addrb", {21'h0, ram_addrb}, {21'h0, ad[AW+1:2]});
    if (m_phase == P_WR) begin
      chk("addra", {21'h0, ram_addra}, {21'h0, m_addr[AW+1:2]});
      chk("dina", ram_dina, wd);
    end
    accepted = sel && rdy && (m_phase != P_ERR1) && tr[1];
    @(posedge clk);
    if (m_phase == P_WR) begin
      for (int k = 0; k < 4; k++) begin
        if (e_wea[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
      end
    end
    if (m_phase == P_ERR1) m_phase = P_ERR2;
    else if (accepted) begin
      m_phase = !legal(ad, sz) ? P_ERR1 : (wr ? P_WR : P_RD);
      m_addr = ad;
      m_size = sz;
    end else m_phase = P_IDLE;
    #1;
  endtask

  task automatic idle(input logic [31:0] wd);
    cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, wd, 1'b1, 1'b0);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    int          n, off;
    rst = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = T_IDLE; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = 32'h0; rdy_ext = 1'b1;
    m_phase = P_IDLE; m_addr = 32'h0; m_size = 3'd0;
    #2;
    chk("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("reset_hresp", {31'h0, HRESP}, 32'h0);
    chk("reset_wea", {28'h0, ram_wea}, 32'h0);
    chk("reset_hrdata", HRDATA, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Word write then idle then read
    cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h2000_0010, 32'h0, 1'b1, 1'b0);
    idle(32'hDEAD_BEEF);
    chk("w1_wea", {28'h0, obs_wea}, 32'hF);
    idle(32'h0);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h2000_0010, 32'h0, 1'b1, 1'b0);
    idle(32'h0);
    chk("w1_read", obs_hrdata, 32'hDEAD_BEEF);

    // Zero word, byte to 0x13, half to 0x10, read back
    cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, T_NS, 1'b1, 3'd0, 32'h13, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, T_NS, 1'b1, 3'd1, 32'h10, 32'hA500_0000, 1'b1, 1'b0);
    chk("byte_wea", {28'h0, obs_wea}, 32'h8);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h10, 32'h0000_1234, 1'b1, 1'b0);
    chk("half_wea", {28'h0, obs_wea}, 32'h3);
    idle(32'h0);
    chk("bh_read", obs_hrdata, 32'hA500_1234);

    // Back-to-back write->read forwarding, full word and single byte
    cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h40, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h40, 32'h1122_3344, 1'b1, 1'b0);
    idle(32'h0);
    chk("fwd_word", obs_hrdata, 32'h1122_3344);
    cyc(1'b1, T_NS, 1'b1, 3'd0, 32'h41, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h40, 32'h0000_FF00, 1'b1, 1'b0);
    idle(32'h0);
    chk("fwd_byte", obs_hrdata, 32'h1122_FF44);

    // Misaligned word write; an address phase offered during ERR1 must be ignored
    cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h02, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h44, 32'h7777_7777, 1'b1, 1'b0);
    chk("err1_rdy", {31'h0, obs_rdy}, 32'h0);
    chk("err1_resp", {31'h0, obs_resp}, 32'h1);
    idle(32'h7777_7777);
    chk("err2_rdy", {31'h0, obs_rdy}, 32'h1);
    chk("err2_resp", {31'h0, obs_resp}, 32'h1);
    idle(32'h7777_7777);
    chk("err_no_wea", {28'h0, obs_wea}, 32'h0);
    // HSIZE=3 read, next read accepted during ERR2
    cyc(1'b1, T_NS, 1'b0, 3'd3, 32'h40, 32'h0, 1'b1, 1'b0);
    idle(32'h0);
    chk("sz3_err1_rdy", {31'h0, obs_rdy}, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 1'b0);
    chk("sz3_err2_resp", {31'h0, obs_resp}, 32'h1);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h44, 32'h0, 1'b1, 1'b0);
    chk("after_err_40", obs_hrdata, 32'h1122_FF44);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h00, 32'h0, 1'b1, 1'b0);
    chk("after_err_44", obs_hrdata, 32'h0);
    idle(32'h0);
    chk("after_err_00", obs_hrdata, 32'h0);

    // HREADY low and BUSY: no capture
    cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h48, 32'h0, 1'b0, 1'b0);
    idle(32'h5555_5555);
    chk("hready0_wea", {28'h0, obs_wea}, 32'h0);
    cyc(1'b1, T_BUSY, 1'b1, 3'd2, 32'h48, 32'h0, 1'b1, 1'b0);
    chk("busy_rdy", {31'h0, obs_rdy}, 32'h1);
    idle(32'h5555_5555);
    chk("busy_wea", {28'h0, obs_wea}, 32'h0);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h48, 32'h0, 1'b1, 1'b0);
    idle(32'h0);
    chk("hready0_read", obs_hrdata, 32'h0);

    // Reset during a write data phase drops the write
    cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h40, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b1);
    cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 1'b0);
    chk("post_rst_rdy", {31'h0, obs_rdy}, 32'h1);
    idle(32'h0);
    chk("post_rst_read", obs_hrdata, 32'h1122_FF44);

    // Random traffic over a few aliased words
    for (int r = 0; r < 800; r++) begin
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      n = (sz <= 3'd2) ? (1 << sz) : 1;
      off = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : (int'($urandom_range(0, 3)) / n) * n;
      ad = ($urandom() & 32'hFFFF_E000) | (32'($urandom_range(0, 7)) << 2) | 32'(off);
      cyc($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), sz, ad,
          $urandom(), $urandom_range(0, 7) != 0, 1'b0);
    end
    idle(32'h0);
    idle(32'h0);
    idle(32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
